alu_fpga_console: RTL and testbench

//  Board-level ALU exerciser, successor to the fixed 16-bit HEX0..3 ALU wrapper. Debounces the

---
 rtl/alu_fpga_console.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_alu_fpga_console.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_fpga_console.sv
// Board-level ALU exerciser: debounced pushbuttons capture operands and an
// opcode from the switches, execute on demand, and page the live switch value
// or the 32-bit result across NUM_DIGITS seven-segment digits.

package cpu_types_pkg;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } aluop_t;
endpackage

// Purely combinational 32-bit ALU with zero / signed-overflow / negative flags.
module alu
  import cpu_types_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] y_o,
  output logic        zero_o,
  output logic        ovf_o,
  output logic        neg_o
);

  // Operation select; overflow is only meaningful for signed add/subtract.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    y_o   = '0;
    ovf_o = 1'b0;
    case (aluop_t'(op_i))
      ALU_SLL:  y_o = a_i << b_i[4:0];
      ALU_SRL:  y_o = a_i >> b_i[4:0];
      ALU_ADD: begin
        y_o   = a_i + b_i;
        ovf_o = (a_i[31] == b_i[31]) && (y_o[31] != a_i[31]);
      end
      ALU_SUB: begin
        y_o   = a_i - b_i;
        ovf_o = (a_i[31] != b_i[31]) && (y_o[31] != a_i[31]);
      end
      ALU_AND:  y_o = a_i & b_i;
      ALU_OR:   y_o = a_i | b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_NOR:  y_o = ~(a_i | b_i);
      ALU_SLT:  y_o = {31'b0, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: y_o = {31'b0, (a_i < b_i)};
      default:  y_o = '0;
    endcase
  end

  assign zero_o = (y_o == 32'h0);
  assign neg_o  = y_o[31];

endmodule

// One pushbutton: 2-flop synchroniser plus press/release debounce FSM that
// emits a single-cycle pulse per accepted press.
module key_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic pulse_o
);

  typedef enum logic [1:0] {DB_IDLE, DB_PRESS_CNT, DB_HELD, DB_REL_CNT} db_state_t;

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             armed_q;
  db_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;
  logic             key_up;

  assign key_up  = sync_q[1];
  assign pulse_o = pulse_q;

  // Synchronise, then count consecutive stable samples in each direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // The synchroniser resets to "pressed" and armed_q clears, so a key held
      // through reset must be seen released before it can ever pulse.
      sync_q  <= 2'b00;
      armed_q <= 1'b0;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      sync_q  <= {sync_q[0], key_n_i};
      pulse_q <= 1'b0;
      if (key_up) armed_q <= 1'b1;
      case (state_q)
        DB_IDLE: begin
          if (!key_up && armed_q) begin
            if (CNT_LAST == '0) begin
              state_q <= DB_HELD;
              pulse_q <= 1'b1;
            end else begin
              state_q <= DB_PRESS_CNT;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        DB_PRESS_CNT: begin
          if (key_up) begin
            state_q <= DB_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_HELD;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DB_HELD: begin
          if (key_up) begin
            if (CNT_LAST == '0) begin
              state_q <= DB_IDLE;
            end else begin
              state_q <= DB_REL_CNT;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        DB_REL_CNT: begin
          if (!key_up) begin
            state_q <= DB_HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DB_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= DB_IDLE;
      endcase
    end
  end

endmodule

// Top level. NUM_DIGITS must be 1, 2, 4 or 8 so the pages tile the 32-bit value.
module alu_fpga_console
  import cpu_types_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DB_CYCLES  = 16
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [3:0]              KEY,
  input  logic [17:0]             SW,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic [3:0]              LEDR
);

  localparam int PAGES  = 8 / NUM_DIGITS;
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);

  typedef enum logic {ST_EDIT, ST_RESULT} mode_t;

  logic [3:0]              key_pulse;
  logic [31:0]             ext;
  logic [31:0]             src;
  logic [31:0]             alu_y;
  logic                    alu_zero;
  logic                    alu_ovf;
  logic                    alu_neg;
  logic [31:0]             a_q;
  logic [31:0]             b_q;
  logic [31:0]             result_q;
  aluop_t                  aluop_q;
  logic [2:0]              flags_q;
  mode_t                   mode_q;
  logic [PAGE_W-1:0]       page_q;
  logic [7*NUM_DIGITS-1:0] hex_d;
  logic [7*NUM_DIGITS-1:0] hex_q;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (CLK),
      .rst_n   (nRST),
      .key_n_i (KEY[k]),
      .pulse_o (key_pulse[k])
    );
  end

  assign ext = SW[16] ? {{16{SW[15]}}, SW[15:0]} : {16'h0, SW[15:0]};

  alu u_alu (
    .a_i    (a_q),
    .b_i    (b_q),
    .op_i   (aluop_q),
    .y_o    (alu_y),
    .zero_o (alu_zero),
    .ovf_o  (alu_ovf),
    .neg_o  (alu_neg)
  );

  // Key actions. Execute may coincide with one of the other actions and always
  // sees the pre-edge registers; among load-operand, load-op and page only the
  // highest priority one takes effect, and page is dropped whenever execute fires.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      aluop_q  <= aluop_t'(4'h0);
      flags_q  <= '0;
      mode_q   <= ST_EDIT;
      page_q   <= '0;
    end else begin
      if (key_pulse[2]) begin
        result_q <= alu_y;
        flags_q  <= {alu_neg, alu_ovf, alu_zero};
        mode_q   <= ST_RESULT;
        page_q   <= '0;
      end
      if (key_pulse[0]) begin
        if (SW[17]) b_q <= ext;
        else        a_q <= ext;
        if (!key_pulse[2]) mode_q <= ST_EDIT;
      end else if (key_pulse[1]) begin
        aluop_q <= aluop_t'(SW[3:0]);
        if (!key_pulse[2]) mode_q <= ST_EDIT;
      end else if (key_pulse[3] && !key_pulse[2]) begin
        page_q <= (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
      end
    end
  end

  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    case (nib)
      4'h0: seg_font = 7'b1000000;
      4'h1: seg_font = 7'b1111001;
      4'h2: seg_font = 7'b0100100;
      4'h3: seg_font = 7'b0110000;
      4'h4: seg_font = 7'b0011001;
      4'h5: seg_font = 7'b0010010;
      4'h6: seg_font = 7'b0000010;
      4'h7: seg_font = 7'b1111000;
      4'h8: seg_font = 7'b0000000;
      4'h9: seg_font = 7'b0010000;
      4'hA: seg_font = 7'b0001000;
      4'hB: seg_font = 7'b0000011;
      4'hC: seg_font = 7'b1000110;
      4'hD: seg_font = 7'b0100001;
      4'hE: seg_font = 7'b0000110;
      default: seg_font = 7'b0001110;
    endcase
  endfunction

  // Select the visible page of the display source and encode each nibble.
  always_comb begin
    logic [2:0] nib_idx;
    nib_idx = '0;
    src     = (mode_q == ST_RESULT) ? result_q : ext;
    hex_d   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib_idx = 3'(int'(page_q) * NUM_DIGITS + i);
      hex_d[7*i +: 7] = seg_font(src[{nib_idx, 2'b00} +: 4]);
    end
  end

  // Display register: blank in reset, then follows the source one cycle later.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) hex_q <= '1;
    else       hex_q <= hex_d;
  end

  assign HEX  = hex_q;
  assign LEDR = {(mode_q == ST_RESULT), flags_q};

endmodule

// File: tb/tb_alu_fpga_console.sv
// Directed bench for alu_fpga_console: reset/bounce/latency sequences, a
// console vector table run on 4- and 8-digit instances, and an ALU flag table.
module tb_alu_fpga_console;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  KEY;
  logic [17:0] SW;
  logic [27:0] hex4;
  logic [55:0] hex8;
  logic [3:0]  ledr4;
  logic [3:0]  ledr8;

  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_op;
  logic        alu_z, alu_v, alu_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  alu_fpga_console #(.NUM_DIGITS(4), .DB_CYCLES(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .KEY(KEY), .SW(SW), .HEX(hex4), .LEDR(ledr4)
  );

  alu_fpga_console #(.NUM_DIGITS(8), .DB_CYCLES(4)) dut8 (
    .CLK(CLK), .nRST(nRST), .KEY(KEY), .SW(SW), .HEX(hex8), .LEDR(ledr8)
  );

  alu u_alu_only (
    .a_i(alu_a), .b_i(alu_b), .op_i(alu_op),
    .y_o(alu_y), .zero_o(alu_z), .ovf_o(alu_v), .neg_o(alu_n)
  );

  typedef struct {
    string       name;
    logic [17:0] sw;
    logic [3:0]  keys;
    logic [15:0] disp4;
    logic [31:0] disp8;
    logic [3:0]  ledr;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] y;
    logic [2:0]  nvz;
  } alu_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  function automatic logic [55:0] hex_img(input logic [31:0] v, input int n);
    logic [55:0] img;
    img = '1;
    for (int i = 0; i < n; i++) img[7*i +: 7] = font(v[4*i +: 4]);
    return img;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [3:0] mask);
    KEY = ~mask;
    tick(8);
    KEY = 4'hF;
    tick(10);
  endtask

  vec_t     tbl [16];
  alu_vec_t atbl [7];

  initial begin
    logic [55:0] img;

    tbl[0]  = '{"loadA_sext",   18'h1_8000, 4'b0001, 16'h8000, 32'hFFFF8000, 4'b0000};
    tbl[1]  = '{"loadB",        18'h2_0001, 4'b0001, 16'h0001, 32'h00000001, 4'b0000};
    tbl[2]  = '{"op_add",       18'h0_0002, 4'b0010, 16'h0002, 32'h00000002, 4'b0000};
    tbl[3]  = '{"exec_add",     18'h0_0002, 4'b0100, 16'h8001, 32'hFFFF8001, 4'b1100};
    tbl[4]  = '{"page1",        18'h0_0002, 4'b1000, 16'hFFFF, 32'hFFFF8001, 4'b1100};
    tbl[5]  = '{"page_wrap",    18'h0_0002, 4'b1000, 16'h8001, 32'hFFFF8001, 4'b1100};
    tbl[6]  = '{"loadA5_hold",  18'h0_0005, 4'b0001, 16'h0005, 32'h00000005, 4'b0100};
    tbl[7]  = '{"loadB5",       18'h2_0005, 4'b0001, 16'h0005, 32'h00000005, 4'b0100};
    tbl[8]  = '{"op_sub",       18'h0_0003, 4'b0010, 16'h0003, 32'h00000003, 4'b0100};
    tbl[9]  = '{"exec_sub_z",   18'h0_0003, 4'b0100, 16'h0000, 32'h00000000, 4'b1001};
    tbl[10] = '{"exec_loadA",   18'h0_0009, 4'b0101, 16'h0000, 32'h00000000, 4'b1001};
    tbl[11] = '{"exec_newA",    18'h0_0009, 4'b0100, 16'h0004, 32'h00000004, 4'b1000};
    tbl[12] = '{"op_and_page",  18'h0_0002, 4'b1010, 16'h0002, 32'h00000002, 4'b0000};
    tbl[13] = '{"exec_add2",    18'h0_0002, 4'b0100, 16'h000E, 32'h0000000E, 4'b1000};
    tbl[14] = '{"loadB_zext",   18'h2_F00D, 4'b0001, 16'hF00D, 32'h0000F00D, 4'b0000};
    tbl[15] = '{"exec_add3",    18'h2_F00D, 4'b0100, 16'hF016, 32'h0000F016, 4'b1000};

    atbl[0] = '{"alu_add_ovf",  32'h7FFFFFFF, 32'h00000001, ALU_ADD,  32'h80000000, 3'b110};
    atbl[1] = '{"alu_sub_zero", 32'h00000005, 32'h00000005, ALU_SUB,  32'h00000000, 3'b001};
    atbl[2] = '{"alu_sub_ovf",  32'h80000000, 32'h00000001, ALU_SUB,  32'h7FFFFFFF, 3'b010};
    atbl[3] = '{"alu_sll",      32'h00000001, 32'h00000004, ALU_SLL,  32'h00000010, 3'b000};
    atbl[4] = '{"alu_and",      32'h0000F0F0, 32'h00000FF0, ALU_AND,  32'h000000F0, 3'b000};
    atbl[5] = '{"alu_slt",      32'hFFFFFFFF, 32'h00000000, ALU_SLT,  32'h00000001, 3'b000};
    atbl[6] = '{"alu_sltu",     32'hFFFFFFFF, 32'h00000000, ALU_SLTU, 32'h00000000, 3'b001};

    // Reset asserted while KEY[0] is already held.
    nRST = 1'b1;
    KEY  = 4'b1110;
    SW   = 18'h0_0012;
    alu_a = '0; alu_b = '0; alu_op = '0;
    #2 nRST = 1'b0;
    tick(3);
    @(negedge CLK);
    check("rst_hex4_blank", 64'(hex4), 64'({28{1'b1}}));
    check("rst_hex8_blank", 64'(hex8), {64{1'b1}} >> 8);
    check("rst_ledr", 64'(ledr4), 64'h0);
    nRST = 1'b1;
    #1;
    check("rst_hex_until_clk", 64'(hex4), 64'({28{1'b1}}));
    tick(20);
    @(negedge CLK);
    check("rst_press_discard", 64'(dut4.a_q), 64'h0);
    img = hex_img(32'h00000012, 4);
    check("rst_hex_shows_sw", 64'(hex4), 64'(img[27:0]));
    check("rst_ledr_after", 64'(ledr4), 64'h0);
    KEY = 4'hF;
    tick(12);

    // Bounce: two 3-cycle lows separated by one high never qualify.
    SW  = 18'h0_0034;
    KEY = 4'b1110; tick(3);
    KEY = 4'b1111; tick(1);
    KEY = 4'b1110; tick(3);
    KEY = 4'b1111; tick(12);
    @(negedge CLK);
    check("bounce_no_load", 64'(dut4.a_q), 64'h0);

    // Clean press: the load lands exactly 2+4+1 edges after the fall.
    KEY = 4'b1110;
    tick(6);
    check("latency_not_early", 64'(dut4.a_q), 64'h0);
    tick(1);
    check("latency_load", 64'(dut4.a_q), 64'h34);
    SW = 18'h0_0056;
    tick(20);
    check("held_no_repulse", 64'(dut4.a_q), 64'h34);
    KEY = 4'hF;
    tick(12);
    check("release_no_load", 64'(dut4.a_q), 64'h34);

    // Console vector table, applied to both display widths.
    for (int i = 0; i < 16; i++) begin
      SW = tbl[i].sw;
      press(tbl[i].keys);
      @(negedge CLK);
      img = hex_img({16'h0, tbl[i].disp4}, 4);
      check({tbl[i].name, "_hex4"}, 64'(hex4), 64'(img[27:0]));
      img = hex_img(tbl[i].disp8, 8);
      check({tbl[i].name, "_hex8"}, 64'(hex8), 64'(img));
      check({tbl[i].name, "_ledr"}, 64'(ledr4), 64'(tbl[i].ledr));
    end

    // Standalone ALU flag corners that switch-sized operands cannot reach.
    for (int i = 0; i < 7; i++) begin
      alu_a  = atbl[i].a;
      alu_b  = atbl[i].b;
      alu_op = atbl[i].op;
      #1;
      check({atbl[i].name, "_y"}, 64'(alu_y), 64'(atbl[i].y));
      check({atbl[i].name, "_nvz"}, 64'({alu_n, alu_v, alu_z}), 64'(atbl[i].nvz));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
